// File: rtl/rfdc_pkg.sv
// Shared RF data converter definitions: sample width and playback FSM states.
package rfdc_pkg;
   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DRAIN = 2'd2
   } play_state_e;
endpackage

// File: rtl/dac_axis_playback_if.sv
// AXI4-Stream link from the playback source to the DAC tile.
// Valid/ready rule: a beat transfers on a cycle where tvalid and tready are both 1;
// once tvalid is 1 the master holds tvalid and tdata unchanged until that transfer.
interface dac_axis_playback_if #(
   parameter int NUMBER_OF_LINE = 8
);
   import rfdc_pkg::*;

   logic                                 tvalid;
   logic [SAMPLE_W*NUMBER_OF_LINE-1:0]   tdata;
   logic                                 tready;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry output stage with empty-bypass: an arriving word goes straight out
// when nothing is queued and the sink is ready, otherwise it is parked.
module axis_skid_buffer #(
   parameter int W = 129
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [1:0]   count
);
   logic [W-1:0] buf_q [2];
   logic [W-1:0] buf_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         bypass, push, pop_buf;

   // Output selection, bypass decision and queue bookkeeping.
   always_comb begin
      out_valid = (count_q != 2'd0) || in_valid;
      out_data  = '0;
      if (count_q != 2'd0) begin
         out_data = buf_q[rd_ptr_q];
      end else if (in_valid) begin
         out_data = in_data;
      end
      bypass   = (count_q == 2'd0) && out_ready;
      push     = in_valid && !bypass;
      pop_buf  = (count_q != 2'd0) && out_ready;
      buf_d    = buf_q;
      if (push) begin
         buf_d[wr_ptr_q] = in_data;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop_buf;
      count_d  = count_q + {1'b0, push} - {1'b0, pop_buf};
   end

   assign count = count_q;

   // Queue storage and pointers; cleared so tdata reads zero out of reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         buf_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         buf_q    <= buf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/dac_axis_playback.sv
// Waveform playback source for one DAC tile: block-RAM waveform store read out
// once or looped as an AXI4-Stream master that honours back-pressure.
module dac_axis_playback
   import rfdc_pkg::*;
#(
   parameter int NUMBER_OF_LINE = 8,
   parameter int ADDR_W         = 10
) (
   input  logic                               clock,
   input  logic                               resetn,
   input  logic                               wr_en,
   input  logic [ADDR_W-1:0]                  wr_addr,
   input  logic [SAMPLE_W*NUMBER_OF_LINE-1:0] wr_data,
   input  logic                               play_start,
   input  logic                               play_stop,
   input  logic [ADDR_W:0]                    play_length,
   input  logic                               loop_en,
   dac_axis_playback_if.master                m_axis,
   output logic                               busy,
   output logic                               pass_done,
   output logic [15:0]                        stall_count,
   output play_state_e                        state_dbg
);
   localparam int DW    = SAMPLE_W * NUMBER_OF_LINE;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [DW-1:0]     mem [DEPTH];
   logic [DW-1:0]     rd_data_q;

   play_state_e       state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;
   logic [15:0]       stall_q, stall_d;
   logic              rd_en, start_ok;

   logic              sb_valid;
   logic [DW:0]       sb_data;
   logic [1:0]        sb_count;
   logic              hs;
   logic [2:0]        occ_next;

   // Words held downstream after this cycle: queued + arriving - leaving.
   assign hs       = sb_valid && m_axis.tready;
   assign occ_next = {1'b0, sb_count} + {2'b0, rd_valid_q} - {2'b0, hs};

   // Playback sequencing: a read is issued only if its word will have a slot.
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      last_addr_d = last_addr_q;
      rd_en       = 1'b0;
      rd_last_d   = 1'b0;
      start_ok    = 1'b0;
      case (state_q)
         IDLE: begin
            if (play_start && !play_stop && (play_length != '0)) begin
               state_d     = PLAY;
               rd_addr_d   = '0;
               start_ok    = 1'b1;
               // Lengths of DEPTH or more all play the whole memory.
               last_addr_d = play_length[ADDR_W] ? '1 : (play_length[ADDR_W-1:0] - ADDR_ONE);
            end
         end
         PLAY: begin
            if (play_stop) begin
               state_d = DRAIN;
            end else if (occ_next <= 3'd1) begin
               rd_en     = 1'b1;
               rd_last_d = (rd_addr_q == last_addr_q);
               if (rd_addr_q == last_addr_q) begin
                  rd_addr_d = '0;
                  if (!loop_en) begin
                     state_d = DRAIN;
                  end
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_ONE;
               end
            end
         end
         DRAIN: begin
            if (occ_next == 3'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      rd_valid_d = rd_en;
   end

   // Back-pressure counter, restarted by each accepted start, saturating.
   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if (sb_valid && !m_axis.tready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Control and status registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         last_addr_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         last_addr_q <= last_addr_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         stall_q     <= stall_d;
      end
   end

   // Waveform RAM: one write port, one read-first synchronous read port.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr_q];
      end
   end

   axis_skid_buffer #(.W(DW + 1)) u_skid (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (rd_valid_q),
      .in_data   ({rd_last_q, rd_data_q}),
      .out_valid (sb_valid),
      .out_data  (sb_data),
      .out_ready (m_axis.tready),
      .count     (sb_count)
   );

   assign m_axis.tvalid = sb_valid;
   assign m_axis.tdata  = sb_data[DW-1:0];
   assign pass_done     = hs && sb_data[DW];
   assign busy          = (state_q != IDLE);
   assign stall_count   = stall_q;
   assign state_dbg     = state_q;
endmodule

// File: tb/tb_dac_axis_playback.sv
// Directed-plus-random bench for dac_axis_playback against a word-sequence model.
module tb_dac_axis_playback;
   import rfdc_pkg::*;

   localparam int NL    = 8;
   localparam int AW    = 6;
   localparam int DW    = 16 * NL;
   localparam int DEPTH = 2 ** AW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          play_start = 1'b0;
   logic          play_stop = 1'b0;
   logic [AW:0]   play_length = '0;
   logic          loop_en = 1'b0;
   logic          busy, pass_done;
   logic [15:0]   stall_count;
   play_state_e   state_dbg;

   dac_axis_playback_if #(.NUMBER_OF_LINE(NL)) m_if ();

   dac_axis_playback #(.NUMBER_OF_LINE(NL), .ADDR_W(AW)) dut (
      .clock       (clk),
      .resetn      (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .play_start  (play_start),
      .play_stop   (play_stop),
      .play_length (play_length),
      .loop_en     (loop_en),
      .m_axis      (m_if),
      .busy        (busy),
      .pass_done   (pass_done),
      .stall_count (stall_count),
      .state_dbg   (state_dbg)
   );

   // ---------------- reference model state ----------------
   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] exp_q [$];
   int mon_base = 0, mon_len = 0, pd_base = 0, pderr_base = 0, stall_base = 0, hold_base = 0;

   // ---------------- monitor (samples on falling edge) ----------------
   logic [DW-1:0] obs_mem [4096];
   int            obs_cyc [4096];
   int            beats_n = 0, cyc_n = 0, pd_n = 0, pd_err = 0, stall_n = 0, hold_err = 0;
   int            busy_fall_cyc = 0;
   logic          busy_prev = 1'b0, stalled_q = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          hs_w, pd_exp;

   assign hs_w   = m_if.tvalid && m_if.tready;
   assign pd_exp = (mon_len != 0) ? (hs_w && (((beats_n - mon_base) % mon_len) == mon_len - 1)) : 1'b0;

   always @(negedge clk) begin
      cyc_n <= cyc_n + 1;
      if (hs_w) begin
         obs_mem[beats_n] <= m_if.tdata;
         obs_cyc[beats_n] <= cyc_n;
         beats_n          <= beats_n + 1;
      end
      if (pass_done) pd_n <= pd_n + 1;
      if (pass_done !== pd_exp) pd_err <= pd_err + 1;
      if (m_if.tvalid && !m_if.tready) stall_n <= stall_n + 1;
      if (stalled_q && rst_n && !(m_if.tvalid && (m_if.tdata === prev_data))) hold_err <= hold_err + 1;
      stalled_q <= m_if.tvalid && !m_if.tready;
      prev_data <= m_if.tdata;
      busy_prev <= busy;
      if (busy_prev && !busy) busy_fall_cyc <= cyc_n;
   end

   // ---------------- checking ----------------
   int n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pat_word(input int a);
      logic [DW-1:0] w;
      for (int k = 0; k < NL; k++) w[16*k +: 16] = 16'((a << 4) | k);
      return w;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
      return w;
   endfunction

   task automatic load_word(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      mem_m[a] = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic start_play(input int len, input logic lp, input logic stp);
      mon_base   = beats_n;
      pd_base    = pd_n;
      pderr_base = pd_err;
      stall_base = stall_n;
      hold_base  = hold_err;
      mon_len    = (len > DEPTH) ? DEPTH : len;
      play_length = (AW+1)'(len);
      loop_en    = lp;
      play_stop  = stp;
      play_start = 1'b1;
      cyc();
      play_start = 1'b0;
      play_stop  = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit, input logic rnd);
      int i = 0;
      while (busy && i < limit) begin
         if (rnd) m_if.tready = ($urandom_range(0, 3) != 0);
         cyc();
         i++;
      end
      chk({tag, "_idle"}, DW'(busy), DW'(0));
      m_if.tready = 1'b1;
      cyc();
   endtask

   // Scoreboard: every beat since the last start must be word (i mod len).
   task automatic check_seq(input string tag, input int n_min, input int n_max);
      int n = beats_n - mon_base;
      chk({tag, "_count_ok"}, DW'(n >= n_min && n <= n_max), DW'(1));
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(mem_m[i % mon_len]);
      for (int i = 0; i < n; i++) chk({tag, "_beat"}, obs_mem[mon_base + i], exp_q.pop_front());
      chk({tag, "_pd_place_err"}, DW'(pd_err - pderr_base), DW'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      logic [3:0] rpat;
      m_if.tready = 1'b0;
      repeat (3) cyc();

      // Reset values.
      chk("rst_tvalid", DW'(m_if.tvalid), DW'(0));
      chk("rst_tdata", m_if.tdata, DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_pass_done", DW'(pass_done), DW'(0));
      chk("rst_stall", DW'(stall_count), DW'(0));
      chk("rst_state", DW'(state_dbg), DW'(IDLE));
      rst_n = 1'b1;
      cyc();

      // 1: single pass, full throughput.
      for (int a = 0; a < 8; a++) load_word(a, pat_word(a));
      m_if.tready = 1'b1;
      start_play(8, 1'b0, 1'b0);
      chk("t1_tvalid_c1", DW'(m_if.tvalid), DW'(0));
      cyc();
      chk("t1_tvalid_c2", DW'(m_if.tvalid), DW'(1));
      chk("t1_tdata_c2", m_if.tdata, mem_m[0]);
      wait_idle("t1", 100, 1'b0);
      check_seq("t1", 8, 8);
      chk("t1_no_gap", DW'(obs_cyc[mon_base + 7] - obs_cyc[mon_base]), DW'(7));
      chk("t1_busy_fall", DW'(busy_fall_cyc - obs_cyc[mon_base + 7]), DW'(1));
      chk("t1_pd_count", DW'(pd_n - pd_base), DW'(1));

      // 2: looped, no gaps across wraps.
      start_play(8, 1'b1, 1'b0);
      for (int i = 0; i < 100 && (beats_n - mon_base) < 24; i++) cyc();
      play_stop = 1'b1;
      cyc();
      play_stop = 1'b0;
      wait_idle("t2", 100, 1'b0);
      check_seq("t2", 24, 30);
      chk("t2_no_gap", DW'(obs_cyc[mon_base + 23] - obs_cyc[mon_base]), DW'(23));
      chk("t2_pd_count", DW'(pd_n - pd_base), DW'((beats_n - mon_base) / 8));

      // 3: looped random waveform under a 1,0,0,1 ready pattern.
      n = $urandom_range(5, 12);
      for (int a = 0; a < n; a++) load_word(a, rnd_word());
      rpat = 4'b1001;
      start_play(n, 1'b1, 1'b0);
      for (int c = 0; c < 80; c++) begin
         m_if.tready = rpat[c % 4];
         cyc();
      end
      m_if.tready = 1'b1;
      play_stop = 1'b1;
      cyc();
      play_stop = 1'b0;
      wait_idle("t3", 100, 1'b0);
      check_seq("t3", 10, 200);
      chk("t3_hold", DW'(hold_err - hold_base), DW'(0));
      chk("t3_stall_count", DW'(stall_count), DW'(stall_n - stall_base));

      // 4: stop while word 3 is on the bus.
      start_play(8, 1'b0, 1'b0);
      for (int i = 0; i < 30 && !(m_if.tvalid && (beats_n - mon_base) == 3); i++) cyc();
      play_stop = 1'b1;
      cyc();
      play_stop = 1'b0;
      wait_idle("t4", 100, 1'b0);
      check_seq("t4", 4, 7);
      chk("t4_no_pd", DW'(pd_n - pd_base), DW'(0));
      chk("t4_tvalid", DW'(m_if.tvalid), DW'(0));
      chk("t4_state", DW'(state_dbg), DW'(IDLE));

      // 5: zero length, start+stop together, oversize length.
      start_play(0, 1'b0, 1'b0);
      repeat (4) cyc();
      chk("t5_len0_busy", DW'(busy), DW'(0));
      chk("t5_len0_beats", DW'(beats_n - mon_base), DW'(0));
      start_play(8, 1'b0, 1'b1);
      repeat (4) cyc();
      chk("t5_startstop_state", DW'(state_dbg), DW'(IDLE));
      chk("t5_startstop_beats", DW'(beats_n - mon_base), DW'(0));
      for (int a = 0; a < DEPTH; a++) load_word(a, rnd_word());
      start_play(DEPTH + 5, 1'b0, 1'b0);
      wait_idle("t5_big", 2000, 1'b1);
      check_seq("t5_big", DEPTH, DEPTH);
      chk("t5_big_pd", DW'(pd_n - pd_base), DW'(1));
      chk("t5_big_hold", DW'(hold_err - hold_base), DW'(0));

      // 6: asynchronous reset mid-play under back-pressure.
      for (int a = 0; a < 8; a++) load_word(a, rnd_word());
      m_if.tready = 1'b0;
      start_play(8, 1'b1, 1'b0);
      repeat (6) cyc();
      chk("t6_stall_pre", DW'(stall_count), DW'(stall_n - stall_base));
      chk("t6_busy_pre", DW'(busy), DW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tvalid", DW'(m_if.tvalid), DW'(0));
      chk("t6_rst_tdata", m_if.tdata, DW'(0));
      chk("t6_rst_busy", DW'(busy), DW'(0));
      chk("t6_rst_pd", DW'(pass_done), DW'(0));
      chk("t6_rst_stall", DW'(stall_count), DW'(0));
      chk("t6_rst_state", DW'(state_dbg), DW'(IDLE));
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int a = 0; a < 8; a++) load_word(a, rnd_word());
      m_if.tready = 1'b1;
      start_play(8, 1'b0, 1'b0);
      cyc();
      chk("t6_first_word", m_if.tdata, mem_m[0]);
      wait_idle("t6", 100, 1'b0);
      check_seq("t6", 8, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
